frame_filler: RTL

FRAME_FILLER -- requirements
Module: frame_filler

---
 rtl/frame_filler.sv | 136 +++++++++++++
 1 files changed

// File: rtl/frame_filler.sv
// frame_filler: fills a frame buffer with one solid colour. Each pixel is
// 32 bits {8'h00, color}. The frame is written as 8-pixel DRAM bursts: one
// address push plus two 128-bit write-data beats of 4 pixels each.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid, color, frame fill request, RGB colour, frame byte base address
//   ready               high only while idle (request accepted when valid)
//   af_full, wdf_full   DRAM address / write-data FIFO full flags
//   af_wr_en, af_addr_din                 address FIFO push and address
//   wdf_wr_en, wdf_din, wdf_mask_din      data FIFO push, data, byte mask
//   fill_cycles         (only with FRAME_FILLER_PERF_EN) busy-cycle count
//                       of the current or most recent fill
//
// Optional build macro: FRAME_FILLER_PERF_EN adds the fill_cycles counter.
// FRAME_W / FRAME_H default to the 800x600 frame; they only exist so the
// geometry can be shrunk. FRAME_W must be a multiple of 8.
module frame_filler #(
    parameter int FRAME_W = 800,
    parameter int FRAME_H = 600
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid,
    input  logic [23:0]  color,
    input  logic [31:0]  frame,
    output logic         ready,
    input  logic         af_full,
    input  logic         wdf_full,
    output logic         af_wr_en,
    output logic [30:0]  af_addr_din,
    output logic         wdf_wr_en,
    output logic [127:0] wdf_din,
    output logic [15:0]  wdf_mask_din
`ifdef FRAME_FILLER_PERF_EN
    ,
    output logic [31:0]  fill_cycles
`endif
);

    localparam logic [9:0] X_LAST = 10'(FRAME_W - 8);
    localparam logic [9:0] Y_LAST = 10'(FRAME_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [9:0]  x, y;
    logic [23:0] color_r;
    logic [5:0]  frame_r;
    logic        accept;
    logic        beat1_done;
    logic        last_burst;

    assign last_burst = (x == X_LAST) && (y == Y_LAST);

    always_comb begin
        state_nxt  = state;
        ready      = 1'b0;
        af_wr_en   = 1'b0;
        wdf_wr_en  = 1'b0;
        accept     = 1'b0;
        beat1_done = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (valid) begin
                    accept    = 1'b1;
                    state_nxt = BEAT0;
                end
            end
            BEAT0: begin
                // Address and first data beat go out together, so both
                // FIFOs must have room before either is pushed.
                if (!af_full && !wdf_full) begin
                    af_wr_en  = 1'b1;
                    wdf_wr_en = 1'b1;
                    state_nxt = BEAT1;
                end
            end
            BEAT1: begin
                if (!wdf_full) begin
                    wdf_wr_en  = 1'b1;
                    beat1_done = 1'b1;
                    state_nxt  = last_burst ? IDLE : BEAT0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            color_r <= '0;
            frame_r <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                color_r <= color;
                frame_r <= frame[27:22];
                x       <= '0;
                y       <= '0;
            end else if (beat1_done) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + 10'd1;
                end else begin
                    x <= x + 10'd8;
                end
            end
        end
    end

    // x[2:0] is always zero: one address covers an 8-pixel burst.
    assign af_addr_din  = {6'b0, frame_r, y, x[9:3], 2'b00};
    assign wdf_din      = {4{8'h00, color_r}};
    assign wdf_mask_din = 16'h0000;

`ifdef FRAME_FILLER_PERF_EN
    always_ff @(posedge clk) begin
        if (rst)
            fill_cycles <= '0;
        else if (accept)
            fill_cycles <= '0;
        else if (state != IDLE)
            fill_cycles <= fill_cycles + 32'd1;
    end
`endif

endmodule
